// File: rtl/signed_bcd_decoder_pkg.sv
// signed_bcd_decoder_pkg: shared types and constants for the signed BCD decoder
package signed_bcd_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
    localparam int         DIGITS         = 3;
    localparam int         WIDTH_DEFAULT  = 8;
    localparam int         CNT_W          = $clog2(WIDTH_DEFAULT);

    // Iteration counter width for a given operand width (counts 0..w-1)
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/signed_bcd_decoder_adjust.sv
// bcd_digit_adjust: add 3 to a BCD digit of 5 or more ahead of a double-dabble shift
module bcd_digit_adjust
    import signed_bcd_decoder_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/signed_bcd_decoder.sv
// signed_bcd_decoder: two's-complement operand to sign flag plus three BCD digits via double-dabble
module signed_bcd_decoder
    import signed_bcd_decoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic             neg,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int CW = cnt_width(WIDTH);
    localparam int BW = 4 * DIGITS;

    state_t            state;
    logic [WIDTH-1:0]  mag;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     adj;
    logic [CW-1:0]     cnt;
    logic              neg_r;
    logic [BW+WIDTH-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd[4*g +: 4]),
            .adjusted (adj[4*g +: 4])
        );
    end

    assign shifted = {adj, mag} << 1;

    // Handshake FSM: capture sign/magnitude, iterate WIDTH shifts, publish digits with a done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mag      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            neg_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            neg      <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        neg_r <= A[WIDTH-1];
                        // Unary minus on WIDTH bits maps the most negative value onto its unsigned magnitude
                        mag   <= A[WIDTH-1] ? -A : A;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= shifted;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        hundreds <= shifted[WIDTH+8 +: 4];
                        tens     <= shifted[WIDTH+4 +: 4];
                        ones     <= shifted[WIDTH   +: 4];
                        neg      <= neg_r;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_bcd_decoder.sv
// tb_signed_bcd_decoder: scoreboard bench with directed vectors for signed_bcd_decoder
module tb_signed_bcd_decoder;

    typedef struct packed {
        logic       neg;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic       busy;
    logic       done;
    logic       neg;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    res_t exp_q[$];
    int   checks;
    int   errors;
    int   done_cnt;

    signed_bcd_decoder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .busy     (busy),
        .done     (done),
        .neg      (neg),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (busy && done)
            check("busy_done_overlap", 1, 0);
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("neg", int'(neg), int'(e.neg));
                check("hundreds", int'(hundreds), int'(e.h));
                check("tens", int'(tens), int'(e.t));
                check("ones", int'(ones), int'(e.o));
            end
        end
    end

    // Issue one conversion; optionally inject a start pulse while busy; returns one cycle after done
    task automatic run(input logic [7:0] a, input logic n, input logic [3:0] h,
                       input logic [3:0] t, input logic [3:0] o, input bit glitch);
        int busy_cyc;
        int lat;
        bit seen;
        busy_cyc = 0;
        lat      = 0;
        seen     = 0;
        start = 1'b1;
        A     = a;
        exp_q.push_back('{n, h, t, o});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (glitch && i == 3) begin
                start = 1'b1;
                A     = 8'hF6;
            end
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cyc++;
        end
        start = 1'b0;
        if (!seen) begin
            check("timeout_waiting_done", 0, 1);
            void'(exp_q.pop_front());
        end else begin
            check("busy_cycles", busy_cyc, 8);
            check("latency", lat, 9);
        end
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_not_busy", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        A        = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_outputs", int'({neg, hundreds, tens, ones}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(8'h85, 1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
        run(8'h80, 1'b1, 4'd1, 4'd2, 4'd8, 1'b0);
        d0 = done_cnt;
        run(8'h7F, 1'b0, 4'd1, 4'd2, 4'd7, 1'b0);
        run(8'hFF, 1'b1, 4'd0, 4'd0, 4'd1, 1'b0);
        check("back_to_back_done_count", done_cnt - d0, 2);
        run(8'h00, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        d0 = done_cnt;
        run(8'h0C, 1'b0, 4'd0, 4'd1, 4'd2, 1'b1);
        repeat (12) @(negedge clk);
        check("ignored_start_done_count", done_cnt - d0, 1);

        // Abort mid-conversion with reset at the fourth SHIFT cycle
        d0 = done_cnt;
        start = 1'b1;
        A     = 8'h85;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        check("hold_during_shift", int'({neg, hundreds, tens, ones}), 13'h0012);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_outputs", int'({neg, hundreds, tens, ones}), 0);
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run(8'h85, 1'b1, 4'd1, 4'd2, 4'd3, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
